fp16_mul_arbiter: RTL and testbench

Round-robin arbiter and pipeline controller that shares one `fp16_mul` datapath between `NUM_REQ` requesters. Each requester presents an operand pair and a rounding mode over a valid/ready handshake. The block grants one request per cycle and issues it to the combinational `fp16_mul` core, then carries the request ID through a `LATENCY`-stage result pipeline. A single response port returns the result, the status flags and the requester ID. It sits between the per-lane issue logic and the shared FP16 multiplier.

---
 rtl/fp16_mul_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fp16_mul_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin arbiter sharing one combinational fp16_mul
// between NUM_REQ requesters, followed by a LATENCY-stage result pipeline.
// Optional feature macro: FP16_MUL_ARB_FFLAGS_EN (per-requester sticky flags).

// Combinational FP16 multiplier, fpnew-style interface and rounding encoding.
module fp16_mul (
   input  logic [31:0] operands_i,
   input  logic [1:0]  is_boxed_i,
   input  logic [2:0]  rnd_mode_i,
   output logic [15:0] result_o,
   output logic [4:0]  status_o
);
   localparam logic [15:0] QNAN = 16'h7E00;

   logic [15:0] a, b;
   logic        sign;
   logic        a_nan, a_snan, a_inf, a_zero;
   logic        b_nan, b_snan, b_inf, b_zero;
   logic [10:0] ma, mb;
   logic [4:0]  ea, eb;
   logic [21:0] prod, pn;
   logic [4:0]  lz;
   logic        found;
   logic signed [7:0] exp_s;
   logic        tiny;
   logic [7:0]  sh_raw;
   logic [4:0]  sh;
   logic [47:0] wide;
   logic [10:0] keep;
   logic        g, st, nx, inc, ovf, ovf_inf, uf;
   logic [4:0]  ef_m1;
   logic [14:0] base, rounded;

   // Unboxed operands are treated as the canonical NaN.
   assign a = is_boxed_i[0] ? operands_i[15:0]  : QNAN;
   assign b = is_boxed_i[1] ? operands_i[31:16] : QNAN;
   assign sign = a[15] ^ b[15];

   assign a_nan  = (&a[14:10]) & (|a[9:0]);
   assign a_snan = a_nan & ~a[9];
   assign a_inf  = (&a[14:10]) & ~(|a[9:0]);
   assign a_zero = ~(|a[14:0]);
   assign b_nan  = (&b[14:10]) & (|b[9:0]);
   assign b_snan = b_nan & ~b[9];
   assign b_inf  = (&b[14:10]) & ~(|b[9:0]);
   assign b_zero = ~(|b[14:0]);

   // Subnormals use exponent 1 with no hidden bit.
   assign ma = {|a[14:10], a[9:0]};
   assign mb = {|b[14:10], b[9:0]};
   assign ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
   assign eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
   assign prod = 22'(ma) * 22'(mb);

   // Leading-zero count of the raw product.
   always_comb begin
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 21; i >= 0; i--) begin
         if (!found && prod[i]) begin
            lz    = 5'(21 - i);
            found = 1'b1;
         end
      end
   end

   // Normalised product 1.f * 2^(exp_s - 15); tiny results shift right into subnormal range.
   assign pn      = prod << lz;
   assign exp_s   = 8'(ea) + 8'(eb) - 8'd14 - 8'(lz);
   assign tiny    = exp_s < 8'sd1;
   assign sh_raw  = 8'd1 - exp_s;
   assign sh      = tiny ? ((sh_raw > 8'd24) ? 5'd24 : sh_raw[4:0]) : 5'd0;
   assign wide    = {pn, 26'd0} >> sh;
   assign keep    = wide[47:37];
   assign g       = wide[36];
   assign st      = |wide[35:0];
   assign nx      = g | st;

   // Hidden bit adds one exponent step, so the field is built as (E-1)*1024 + keep.
   assign ef_m1   = tiny ? 5'd0 : (exp_s[4:0] - 5'd1);
   assign base    = {ef_m1, 10'd0} + 15'(keep);
   assign rounded = base + 15'(inc);
   assign ovf     = (exp_s > 8'sd30) | (rounded[14:10] == 5'h1f);
   assign uf      = nx & (rounded[14:10] == 5'd0);

   // Rounding increment and overflow target per rounding mode.
   always_comb begin
      inc     = g & (st | keep[0]);
      ovf_inf = 1'b1;
      case (rnd_mode_i)
         3'b001: begin inc = 1'b0;          ovf_inf = 1'b0;  end
         3'b010: begin inc = sign & nx;     ovf_inf = sign;  end
         3'b011: begin inc = ~sign & nx;    ovf_inf = ~sign; end
         3'b100: begin inc = g;             ovf_inf = 1'b1;  end
         default: ;
      endcase
   end

   // Special-case priority, then overflow, then the rounded finite result.
   always_comb begin
      result_o = {sign, rounded};
      status_o = {3'b000, uf, nx};
      if (a_nan || b_nan) begin
         result_o = QNAN;
         status_o = {a_snan | b_snan, 4'b0000};
      end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
         result_o = QNAN;
         status_o = 5'b10000;
      end else if (a_inf || b_inf) begin
         result_o = {sign, 15'h7C00};
         status_o = 5'b00000;
      end else if (a_zero || b_zero) begin
         result_o = {sign, 15'h0000};
         status_o = 5'b00000;
      end else if (ovf) begin
         result_o = ovf_inf ? {sign, 15'h7C00} : {sign, 15'h7BFF};
         status_o = 5'b00101;
      end
   end
endmodule

module fp16_mul_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   parameter  int unsigned LATENCY = 2,
   localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   input  logic [NUM_REQ*16-1:0]  req_op_a_i,
   input  logic [NUM_REQ*16-1:0]  req_op_b_i,
   input  logic [NUM_REQ*3-1:0]   req_rnd_i,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic [IDW-1:0]         resp_id_o,
   output logic [15:0]            resp_result_o,
   output logic [4:0]             resp_status_o,
   output logic                   busy_o,
   output logic [NUM_REQ*5-1:0]   fflags_o,
   input  logic [NUM_REQ-1:0]     fflags_clr_i
);
   logic           stall, grant_found, issue;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [15:0]    op_a, op_b, core_res;
   logic [2:0]     op_rnd;
   logic [4:0]     core_st;

   logic           vld_q [LATENCY];
   logic [IDW-1:0] id_q  [LATENCY];
   logic [15:0]    res_q [LATENCY];
   logic [4:0]     st_q  [LATENCY];

   assign stall = resp_valid_o & ~resp_ready_i;

   // First valid requester at or after rr_ptr, with wrap-around.
   always_comb begin
      int unsigned cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (32'(rr_ptr_q) + 32'(i)) % NUM_REQ;
         if (!grant_found && req_valid_i[IDW'(cand)]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(cand);
         end
      end
   end

   assign issue       = grant_found & ~stall & ~rst_i;
   assign req_ready_o = issue ? (NUM_REQ'(1) << grant_idx) : '0;

   assign op_a   = 16'(req_op_a_i >> {grant_idx, 4'b0000});
   assign op_b   = 16'(req_op_b_i >> {grant_idx, 4'b0000});
   assign op_rnd = 3'(req_rnd_i >> (32'(grant_idx) * 3));

   fp16_mul u_core (
      .operands_i (32'({op_b, op_a})),
      .is_boxed_i (2'b11),
      .rnd_mode_i (op_rnd),
      .result_o   (core_res),
      .status_o   (core_st)
   );

   // Pointer advances past the granted requester only on a handshake.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) begin
         rr_ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDW'(1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end

   // Result pipeline: stage 0 captures the issue (or a bubble), whole pipe holds on stall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < LATENCY; s++) begin
            vld_q[s] <= 1'b0;
            id_q[s]  <= '0;
            res_q[s] <= '0;
            st_q[s]  <= '0;
         end
      end else if (!stall) begin
         vld_q[0] <= issue;
         id_q[0]  <= grant_idx;
         res_q[0] <= core_res;
         st_q[0]  <= core_st;
         for (int s = 1; s < LATENCY; s++) begin
            vld_q[s] <= vld_q[s-1];
            id_q[s]  <= id_q[s-1];
            res_q[s] <= res_q[s-1];
            st_q[s]  <= st_q[s-1];
         end
      end
   end

   assign resp_valid_o  = vld_q[LATENCY-1];
   assign resp_id_o     = id_q[LATENCY-1];
   assign resp_result_o = res_q[LATENCY-1];
   assign resp_status_o = st_q[LATENCY-1];

   // Busy whenever any stage holds a valid result.
   always_comb begin
      busy_o = 1'b0;
      for (int s = 0; s < LATENCY; s++) busy_o = busy_o | vld_q[s];
   end

`ifdef FP16_MUL_ARB_FFLAGS_EN
   logic [NUM_REQ*5-1:0] fflags_q, fflags_d;
   logic                 resp_hs;

   assign resp_hs = resp_valid_o & resp_ready_i;

   // Sticky flags: a clear in the same cycle as new flags keeps the new flags.
   always_comb begin
      fflags_d = fflags_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         fflags_d[5*k +: 5] = (fflags_clr_i[k] ? 5'd0 : fflags_q[5*k +: 5]) |
                              ((resp_hs && (32'(resp_id_o) == k)) ? resp_status_o : 5'd0);
      end
   end

   // Sticky flag register.
   always_ff @(posedge clk_i) begin
      if (rst_i) fflags_q <= '0;
      else       fflags_q <= fflags_d;
   end

   assign fflags_o = fflags_q;
`else
   logic unused_fflags_clr;
   assign unused_fflags_clr = |fflags_clr_i;
   assign fflags_o = '0;
`endif
endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed self-checking bench for fp16_mul_arbiter (NUM_REQ=4, LATENCY=2).
module tb_fp16_mul_arbiter;
   localparam int unsigned NR = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [NR-1:0] req_valid_i, req_ready_o, fflags_clr_i;
   logic [NR*16-1:0] req_op_a_i, req_op_b_i;
   logic [NR*3-1:0]  req_rnd_i;
   logic          resp_valid_o, resp_ready_i, busy_o;
   logic [1:0]    resp_id_o;
   logic [15:0]   resp_result_o;
   logic [4:0]    resp_status_o;
   logic [NR*5-1:0] fflags_o;

   int n_checks = 0;
   int n_errors = 0;

   fp16_mul_arbiter #(.NUM_REQ(NR), .LATENCY(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_rnd_i(req_rnd_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
      .resp_result_o(resp_result_o), .resp_status_o(resp_status_o), .busy_o(busy_o),
      .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ops(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] rnd);
      req_op_a_i[16*k +: 16] = a;
      req_op_b_i[16*k +: 16] = b;
      req_rnd_i[3*k +: 3]    = rnd;
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      req_valid_i = '0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic single_issue(input int k, input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] rnd, input logic [15:0] er,
                               input logic [4:0] es);
      set_ops(k, a, b, rnd);
      req_valid_i = NR'(1) << k;
      #1;
      check("single_ready", 32'(req_ready_o), 32'(NR'(1) << k));
      tick();
      req_valid_i = '0;
      check("single_lat_valid", 32'(resp_valid_o), 32'd0);
      check("single_busy", 32'(busy_o), 32'd1);
      tick();
      check("single_valid", 32'(resp_valid_o), 32'd1);
      check("single_id", 32'(resp_id_o), 32'(k));
      check("single_result", 32'(resp_result_o), 32'(er));
      check("single_status", 32'(resp_status_o), 32'(es));
      tick();
   endtask

   // Directed vectors: requester, A, B, rounding mode, expected product and flags.
   int          v_k   [10] = '{1, 2, 3, 1, 2, 0, 3, 0, 1, 2};
   logic [15:0] v_a   [10] = '{16'h7BFF, 16'hFBFF, 16'hC000, 16'h0001, 16'h0001,
                               16'h7C00, 16'h7D00, 16'h0400, 16'h3C01, 16'h3C01};
   logic [15:0] v_b   [10] = '{16'h7BFF, 16'h7BFF, 16'h3E00, 16'h3C00, 16'h3800,
                               16'h0000, 16'h3C00, 16'h3800, 16'h3C01, 16'h3C01};
   logic [2:0]  v_rnd [10] = '{3'd1, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
   logic [15:0] v_res [10] = '{16'h7BFF, 16'hFBFF, 16'hC200, 16'h0001, 16'h0000,
                               16'h7E00, 16'h7E00, 16'h0200, 16'h3C02, 16'h3C03};
   logic [4:0]  v_st  [10] = '{5'h05, 5'h05, 5'h00, 5'h00, 5'h03,
                               5'h10, 5'h10, 5'h00, 5'h01, 5'h01};
   logic [15:0] fair_b   [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};

   initial begin
      rst_i        = 1'b1;
      req_valid_i  = '1;
      req_op_a_i   = '0;
      req_op_b_i   = '0;
      req_rnd_i    = '0;
      resp_ready_i = 1'b1;
      fflags_clr_i = '0;
      tick();
      tick();
      check("rst_ready", 32'(req_ready_o), 32'd0);
      check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_result", 32'(resp_result_o), 32'd0);
      check("rst_fflags", 32'(fflags_o), 32'd0);
      req_valid_i = '0;
      rst_i = 1'b0;
      tick();

      // Basic product and overflow on requester 0, then sticky flag behaviour.
      single_issue(0, 16'h3E00, 16'h4000, 3'd0, 16'h4200, 5'h00);
      single_issue(0, 16'h7BFF, 16'h7BFF, 3'd0, 16'h7C00, 5'h05);
`ifdef FP16_MUL_ARB_FFLAGS_EN
      check("fflags_set", 32'(fflags_o[4:0]), 32'h05);
`else
      check("fflags_tied", 32'(fflags_o), 32'h0);
`endif
      fflags_clr_i = 4'b0001;
      tick();
      fflags_clr_i = '0;
      check("fflags_clr", 32'(fflags_o[4:0]), 32'h0);

      for (int i = 0; i < 10; i++)
         single_issue(v_k[i], v_a[i], v_b[i], v_rnd[i], v_res[i], v_st[i]);

      // Fairness with all requesters valid.
      do_reset();
      for (int k = 0; k < 4; k++) set_ops(k, 16'h3C00, fair_b[k], 3'd0);
      for (int c = 0; c < 11; c++) begin
         req_valid_i = (c < 8) ? 4'hF : 4'h0;
         #1;
         if (c < 8) check("fair_grant", 32'(req_ready_o), 32'(NR'(1) << (c % 4)));
         if (c >= 2 && c < 10) begin
            check("fair_valid", 32'(resp_valid_o), 32'd1);
            check("fair_id", 32'(resp_id_o), 32'((c - 2) % 4));
            check("fair_result", 32'(resp_result_o), 32'(fair_b[(c - 2) % 4]));
         end
         if (c == 10) check("fair_drain", 32'(resp_valid_o), 32'd0);
         tick();
      end

      // Back-pressure: three issues, response held off for three cycles.
      do_reset();
      set_ops(0, 16'h3C00, 16'h3C00, 3'd0);
      set_ops(1, 16'h4000, 16'h4000, 3'd0);
      set_ops(2, 16'h4200, 16'h4000, 3'd0);
      req_valid_i = 4'b0111;
      #1;
      check("bp_grant0", 32'(req_ready_o), 32'h1);
      tick();
      check("bp_grant1", 32'(req_ready_o), 32'h2);
      tick();
      check("bp_grant2", 32'(req_ready_o), 32'h4);
      check("bp_resp0_id", 32'(resp_id_o), 32'd0);
      check("bp_resp0_res", 32'(resp_result_o), 32'h3C00);
      tick();
      req_valid_i  = 4'b1000;
      resp_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_stall_ready", 32'(req_ready_o), 32'd0);
         check("bp_stall_valid", 32'(resp_valid_o), 32'd1);
         check("bp_stall_id", 32'(resp_id_o), 32'd1);
         check("bp_stall_res", 32'(resp_result_o), 32'h4400);
         tick();
      end
      req_valid_i  = '0;
      resp_ready_i = 1'b1;
      #1;
      check("bp_resp1_id", 32'(resp_id_o), 32'd1);
      check("bp_resp1_res", 32'(resp_result_o), 32'h4400);
      tick();
      check("bp_resp2_valid", 32'(resp_valid_o), 32'd1);
      check("bp_resp2_id", 32'(resp_id_o), 32'd2);
      check("bp_resp2_res", 32'(resp_result_o), 32'h4600);
      tick();
      check("bp_done_valid", 32'(resp_valid_o), 32'd0);
      check("bp_done_busy", 32'(busy_o), 32'd0);

      // Pointer wrap: move rr_ptr to 2, then 3 wins over 1.
      single_issue(1, 16'h4000, 16'h4000, 3'd0, 16'h4400, 5'h00);
      req_valid_i = 4'b1010;
      #1;
      check("wrap_first", 32'(req_ready_o), 32'h8);
      tick();
      check("wrap_second", 32'(req_ready_o), 32'h2);
      tick();
      req_valid_i = '0;
      tick();
      tick();
      tick();

      // Reset with two results in flight.
      req_valid_i = 4'b0011;
      #1;
      check("mid_grant0", 32'(req_ready_o), 32'h1);
      tick();
      check("mid_grant1", 32'(req_ready_o), 32'h2);
      tick();
      req_valid_i = '0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("mid_no_resp", 32'(resp_valid_o), 32'd0);
         check("mid_busy", 32'(busy_o), 32'd0);
         tick();
      end
      req_valid_i = 4'b1100;
      #1;
      check("mid_first_grant", 32'(req_ready_o), 32'h4);
      tick();
      req_valid_i = '0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
